// File: rtl/timer_pkg.sv
// Shared definitions for the 8-bit style timer/counter: register map,
// control-field encodings and the TMO priority resolver.
package timer_pkg;

    localparam logic [2:0] ADDR_TCNT  = 3'd0;
    localparam logic [2:0] ADDR_TCORA = 3'd1;
    localparam logic [2:0] ADDR_TCORB = 3'd2;
    localparam logic [2:0] ADDR_TCR   = 3'd3;
    localparam logic [2:0] ADDR_TCSR  = 3'd4;

    localparam int TCR_OVIE_BIT  = 5;
    localparam int TCR_CMIEA_BIT = 6;
    localparam int TCR_CMIEB_BIT = 7;

    localparam int TCSR_OVF_BIT  = 5;
    localparam int TCSR_CMFA_BIT = 6;
    localparam int TCSR_CMFB_BIT = 7;

    typedef enum logic [1:0] {
        CCLR_NONE     = 2'b00,
        CCLR_MATCH_A  = 2'b01,
        CCLR_MATCH_B  = 2'b10,
        CCLR_NONE_ALT = 2'b11
    } cclr_e;

    typedef enum logic [1:0] {
        OS_NONE   = 2'b00,
        OS_DRIVE0 = 2'b01,
        OS_DRIVE1 = 2'b10,
        OS_TOGGLE = 2'b11
    } os_e;

    // Simultaneous A/B requests resolve as toggle > drive 1 > drive 0.
    function automatic logic resolve_tmo(input logic tmo, input os_e act_a, input os_e act_b);
        if (act_a == OS_TOGGLE || act_b == OS_TOGGLE) return !tmo;
        if (act_a == OS_DRIVE1 || act_b == OS_DRIVE1) return 1'b1;
        if (act_a == OS_DRIVE0 || act_b == OS_DRIVE0) return 1'b0;
        return tmo;
    endfunction

endpackage

// File: rtl/timer_compare.sv
// One compare channel: flags a match when the counter is about to load
// the compare value and forwards the channel's output-select action.
module timer_compare
    import timer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             count_en,
    input  logic [WIDTH-1:0] cnt_next,
    input  logic [WIDTH-1:0] cor,
    input  os_e              os,
    output logic             match,
    output os_e              action
);

    always_comb begin
        match  = count_en && (cnt_next == cor);
        action = match ? os : OS_NONE;
    end

endmodule

// File: rtl/timer_counter.sv
// Timer/counter with two compare channels, selectable clear-on-match,
// sticky status flags, level interrupts and a compare-driven output pin.
module timer_counter
    import timer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             CounterClock,
    input  logic             wr_en,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             TMO,
    output logic             CMIA,
    output logic             CMIB,
    output logic             OVI
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] tcnt_q, tcnt_d;
    logic [WIDTH-1:0] tcora_q, tcora_d;
    logic [WIDTH-1:0] tcorb_q, tcorb_d;
    cclr_e            cclr_q, cclr_d;
    logic             ovie_q, ovie_d;
    logic             cmiea_q, cmiea_d;
    logic             cmieb_q, cmieb_d;
    os_e              osa_q, osa_d;
    os_e              osb_q, osb_d;
    logic             ovf_q, ovf_d;
    logic             cmfa_q, cmfa_d;
    logic             cmfb_q, cmfb_d;
    logic             tmo_q, tmo_d;

    logic             wr_tcnt, wr_tcora, wr_tcorb, wr_tcr, wr_tcsr;
    logic             count_en, clear_hit, ovf_hit;
    logic [WIDTH-1:0] cnt_next;
    logic             match_a, match_b;
    os_e              act_a, act_b;

    always_comb begin : count_logic
        wr_tcnt   = wr_en && (addr == ADDR_TCNT);
        wr_tcora  = wr_en && (addr == ADDR_TCORA);
        wr_tcorb  = wr_en && (addr == ADDR_TCORB);
        wr_tcr    = wr_en && (addr == ADDR_TCR);
        wr_tcsr   = wr_en && (addr == ADDR_TCSR);
        // A software TCNT write suppresses the count and every event it would raise.
        count_en  = CounterClock && !wr_tcnt;
        clear_hit = ((cclr_q == CCLR_MATCH_A) && (tcnt_q == tcora_q)) ||
                    ((cclr_q == CCLR_MATCH_B) && (tcnt_q == tcorb_q));
        cnt_next  = clear_hit ? '0 : tcnt_q + WIDTH'(1);
        ovf_hit   = count_en && !clear_hit && (tcnt_q == ALL_ONES);
    end

    timer_compare #(.WIDTH(WIDTH)) u_cmp_a (
        .count_en (count_en),
        .cnt_next (cnt_next),
        .cor      (tcora_q),
        .os       (osa_q),
        .match    (match_a),
        .action   (act_a)
    );

    timer_compare #(.WIDTH(WIDTH)) u_cmp_b (
        .count_en (count_en),
        .cnt_next (cnt_next),
        .cor      (tcorb_q),
        .os       (osb_q),
        .match    (match_b),
        .action   (act_b)
    );

    always_comb begin : next_state
        // NOTE: every _d takes its hold value first so no branch can infer a latch.
        tcnt_d  = tcnt_q;
        tcora_d = tcora_q;
        tcorb_d = tcorb_q;
        cclr_d  = cclr_q;
        ovie_d  = ovie_q;
        cmiea_d = cmiea_q;
        cmieb_d = cmieb_q;
        osa_d   = osa_q;
        osb_d   = osb_q;
        ovf_d   = ovf_q;
        cmfa_d  = cmfa_q;
        cmfb_d  = cmfb_q;

        if (wr_tcnt) begin
            tcnt_d = wdata;
        end else if (count_en) begin
            tcnt_d = cnt_next;
        end
        if (wr_tcora) tcora_d = wdata;
        if (wr_tcorb) tcorb_d = wdata;
        if (wr_tcr) begin
            cclr_d  = cclr_e'(wdata[1:0]);
            ovie_d  = wdata[TCR_OVIE_BIT];
            cmiea_d = wdata[TCR_CMIEA_BIT];
            cmieb_d = wdata[TCR_CMIEB_BIT];
        end
        // Software may only clear flags (write 0); hardware sets are OR-ed last so they win.
        if (wr_tcsr) begin
            osa_d  = os_e'(wdata[1:0]);
            osb_d  = os_e'(wdata[3:2]);
            ovf_d  = ovf_q  && wdata[TCSR_OVF_BIT];
            cmfa_d = cmfa_q && wdata[TCSR_CMFA_BIT];
            cmfb_d = cmfb_q && wdata[TCSR_CMFB_BIT];
        end
        ovf_d  = ovf_d  || ovf_hit;
        cmfa_d = cmfa_d || match_a;
        cmfb_d = cmfb_d || match_b;

        tmo_d = resolve_tmo(tmo_q, act_a, act_b);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q  <= '0;
            tcora_q <= ALL_ONES;
            tcorb_q <= ALL_ONES;
            cclr_q  <= CCLR_NONE;
            ovie_q  <= 1'b0;
            cmiea_q <= 1'b0;
            cmieb_q <= 1'b0;
            osa_q   <= OS_NONE;
            osb_q   <= OS_NONE;
            ovf_q   <= 1'b0;
            cmfa_q  <= 1'b0;
            cmfb_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            tcnt_q  <= tcnt_d;
            tcora_q <= tcora_d;
            tcorb_q <= tcorb_d;
            cclr_q  <= cclr_d;
            ovie_q  <= ovie_d;
            cmiea_q <= cmiea_d;
            cmieb_q <= cmieb_d;
            osa_q   <= osa_d;
            osb_q   <= osb_d;
            ovf_q   <= ovf_d;
            cmfa_q  <= cmfa_d;
            cmfb_q  <= cmfb_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin : read_mux
        rdata = '0;
        case (addr)
            ADDR_TCNT:  rdata = tcnt_q;
            ADDR_TCORA: rdata = tcora_q;
            ADDR_TCORB: rdata = tcorb_q;
            ADDR_TCR: begin
                rdata[1:0]           = cclr_q;
                rdata[TCR_OVIE_BIT]  = ovie_q;
                rdata[TCR_CMIEA_BIT] = cmiea_q;
                rdata[TCR_CMIEB_BIT] = cmieb_q;
            end
            ADDR_TCSR: begin
                rdata[1:0]           = osa_q;
                rdata[3:2]           = osb_q;
                rdata[TCSR_OVF_BIT]  = ovf_q;
                rdata[TCSR_CMFA_BIT] = cmfa_q;
                rdata[TCSR_CMFB_BIT] = cmfb_q;
            end
            default: rdata = '0;
        endcase
    end

    assign TMO  = tmo_q;
    assign CMIA = cmfa_q && cmiea_q;
    assign CMIB = cmfb_q && cmieb_q;
    assign OVI  = ovf_q && ovie_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed scenarios plus randomized traffic against an arithmetic model of the timer.
`timescale 1ns/1ps
module tb_timer_counter;

    localparam int W   = 8;
    localparam int MOD = 256;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         CounterClock = 1'b0;
    logic         wr_en = 1'b0;
    logic [2:0]   addr = 3'd0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] rdata;
    logic         TMO, CMIA, CMIB, OVI;

    int n_checks = 0;
    int n_errors = 0;

    timer_counter #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .CounterClock (CounterClock),
        .wr_en        (wr_en),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .TMO          (TMO),
        .CMIA         (CMIA),
        .CMIB         (CMIB),
        .OVI          (OVI)
    );

    always #5 clk = ~clk;

    // Reference model state, kept as plain integers and flags.
    int m_tcnt, m_tcora, m_tcorb, m_cclr, m_osa, m_osb;
    bit m_ovie, m_cmiea, m_cmieb, m_ovf, m_cmfa, m_cmfb, m_tmo;

    task automatic model_step(input bit r, input bit s, input bit w, input int a, input int d);
        int  nt;
        bit  ev, clr, ma, mb, ov, wr_flags;
        if (r) begin
            m_tcnt = 0; m_tcora = MOD - 1; m_tcorb = MOD - 1;
            m_cclr = 0; m_osa = 0; m_osb = 0;
            m_ovie = 0; m_cmiea = 0; m_cmieb = 0;
            m_ovf = 0; m_cmfa = 0; m_cmfb = 0; m_tmo = 0;
            return;
        end
        ev  = s && !(w && a == 0);
        clr = (m_cclr == 1 && m_tcnt == m_tcora) || (m_cclr == 2 && m_tcnt == m_tcorb);
        nt  = clr ? 0 : (m_tcnt + 1) % MOD;
        ma  = ev && nt == m_tcora;
        mb  = ev && nt == m_tcorb;
        ov  = ev && !clr && m_tcnt == MOD - 1;
        if ((ma && m_osa == 3) || (mb && m_osb == 3))      m_tmo = !m_tmo;
        else if ((ma && m_osa == 2) || (mb && m_osb == 2)) m_tmo = 1;
        else if ((ma && m_osa == 1) || (mb && m_osb == 1)) m_tmo = 0;
        wr_flags = w && a == 4;
        if (w) begin
            case (a)
                0: m_tcnt  = d;
                1: m_tcora = d;
                2: m_tcorb = d;
                3: begin
                    m_cclr  = d % 4;
                    m_ovie  = ((d >> 5) & 1) != 0;
                    m_cmiea = ((d >> 6) & 1) != 0;
                    m_cmieb = ((d >> 7) & 1) != 0;
                end
                4: begin
                    m_osa = d % 4;
                    m_osb = (d / 4) % 4;
                end
                default: ;
            endcase
        end
        if (wr_flags && ((d >> 5) & 1) == 0) m_ovf  = 0;
        if (wr_flags && ((d >> 6) & 1) == 0) m_cmfa = 0;
        if (wr_flags && ((d >> 7) & 1) == 0) m_cmfb = 0;
        if (ev) m_tcnt = nt;
        if (ov) m_ovf  = 1;
        if (ma) m_cmfa = 1;
        if (mb) m_cmfb = 1;
    endtask

    function automatic int model_read(input int a);
        case (a)
            0: return m_tcnt;
            1: return m_tcora;
            2: return m_tcorb;
            3: return m_cmieb * 128 + m_cmiea * 64 + m_ovie * 32 + m_cclr;
            4: return m_cmfb * 128 + m_cmfa * 64 + m_ovf * 32 + m_osb * 4 + m_osa;
            default: return 0;
        endcase
    endfunction

    // One clock: drive inputs, take the edge, advance the model, then release strobes.
    task automatic tick(input bit r, input bit s, input bit w, input int a, input int d);
        rst = r; CounterClock = s; wr_en = w; addr = a[2:0]; wdata = d[W-1:0];
        @(posedge clk);
        model_step(r, s, w, a, d);
        #1;
        rst = 1'b0; CounterClock = 1'b0; wr_en = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        tick(1'b0, 1'b0, 1'b1, a, d);
    endtask

    task automatic strobe();
        tick(1'b0, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic rd(input int a);
        addr = a[2:0];
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] exp_regs [8] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tick(1'b1, 1'b1, 1'b1, 0, 8'h33);
        for (int i = 0; i < 8; i++) begin
            rd(i);
            n_checks++;
            if (rdata !== exp_regs[i]) begin
                n_errors++;
                $display("FAIL reset_reg%0d: got %02h want %02h", i, rdata, exp_regs[i]);
            end
        end
        n_checks++;
        if ({TMO, CMIA, CMIB, OVI} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_outputs: got %04b want 0000", {TMO, CMIA, CMIB, OVI});
        end
    endtask

    task automatic test_clear_match_a();
        logic [W-1:0] exp_cnt;
        logic         exp_cmia;
        tick(1'b1, 1'b0, 1'b0, 0, 0);
        wr(1, 5);
        wr(3, 8'h41);
        for (int k = 1; k <= 12; k++) begin
            strobe();
            rd(0);
            exp_cnt  = W'(k % 6);
            exp_cmia = (k == 5 || k == 6 || k >= 11);
            n_checks++;
            if (rdata !== exp_cnt) begin
                n_errors++;
                $display("FAIL clear_a_tcnt strobe %0d: got %02h want %02h", k, rdata, exp_cnt);
            end
            n_checks++;
            if (CMIA !== exp_cmia) begin
                n_errors++;
                $display("FAIL clear_a_cmia strobe %0d: got %b want %b", k, CMIA, exp_cmia);
            end
            if (k == 6) wr(4, 8'h00);
        end
        rd(4);
        n_checks++;
        if (rdata !== 8'h40) begin
            n_errors++;
            $display("FAIL clear_a_tcsr: got %02h want 40", rdata);
        end
    endtask

    task automatic test_overflow();
        tick(1'b1, 1'b0, 1'b0, 0, 0);
        wr(1, 8'h80);
        wr(2, 8'h80);
        wr(3, 8'h20);
        wr(0, 8'hFE);
        strobe();
        rd(0);
        n_checks++;
        if (rdata !== 8'hFF || OVI !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_first: got tcnt=%02h ovi=%b want tcnt=ff ovi=0", rdata, OVI);
        end
        strobe();
        rd(0);
        n_checks++;
        if (rdata !== 8'h00 || OVI !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_wrap: got tcnt=%02h ovi=%b want tcnt=00 ovi=1", rdata, OVI);
        end
        rd(4);
        n_checks++;
        if (rdata !== 8'h20) begin
            n_errors++;
            $display("FAIL ovf_tcsr: got %02h want 20", rdata);
        end
    endtask

    task automatic test_tmo_priority();
        tick(1'b1, 1'b0, 1'b0, 0, 0);
        wr(1, 3);
        wr(2, 3);
        wr(4, 8'h0D);
        strobe();
        strobe();
        n_checks++;
        if (TMO !== 1'b0) begin
            n_errors++;
            $display("FAIL tmo_before_match: got %b want 0", TMO);
        end
        strobe();
        n_checks++;
        if (TMO !== 1'b1) begin
            n_errors++;
            $display("FAIL tmo_toggle_wins: got %b want 1", TMO);
        end
        rd(4);
        n_checks++;
        if (rdata !== 8'hCD) begin
            n_errors++;
            $display("FAIL tmo_tcsr: got %02h want cd", rdata);
        end
        wr(4, 8'h05);
        wr(0, 2);
        strobe();
        n_checks++;
        if (TMO !== 1'b0) begin
            n_errors++;
            $display("FAIL tmo_drive0: got %b want 0", TMO);
        end
        wr(4, 8'h09);
        wr(0, 2);
        strobe();
        n_checks++;
        if (TMO !== 1'b1) begin
            n_errors++;
            $display("FAIL tmo_drive1_wins: got %b want 1", TMO);
        end
    endtask

    task automatic test_flag_race();
        tick(1'b1, 1'b0, 1'b0, 0, 0);
        wr(4, 8'hE0);
        rd(4);
        n_checks++;
        if (rdata !== 8'h00) begin
            n_errors++;
            $display("FAIL sw_cannot_set: got %02h want 00", rdata);
        end
        wr(1, 2);
        wr(3, 8'h01);
        strobe();
        strobe();
        rd(4);
        n_checks++;
        if (rdata !== 8'h40) begin
            n_errors++;
            $display("FAIL race_cmfa_set: got %02h want 40", rdata);
        end
        wr(4, 8'h00);
        rd(4);
        n_checks++;
        if (rdata !== 8'h00) begin
            n_errors++;
            $display("FAIL race_sw_clear: got %02h want 00", rdata);
        end
        strobe();
        strobe();
        tick(1'b0, 1'b1, 1'b1, 4, 8'h00);
        rd(4);
        n_checks++;
        if (rdata !== 8'h40) begin
            n_errors++;
            $display("FAIL race_hw_wins: got %02h want 40", rdata);
        end
    endtask

    task automatic test_write_priority();
        tick(1'b1, 1'b0, 1'b0, 0, 0);
        wr(1, 8'h40);
        tick(1'b0, 1'b1, 1'b1, 0, 8'h40);
        rd(0);
        n_checks++;
        if (rdata !== 8'h40) begin
            n_errors++;
            $display("FAIL wr_prio_tcnt: got %02h want 40", rdata);
        end
        rd(4);
        n_checks++;
        if (rdata !== 8'h00) begin
            n_errors++;
            $display("FAIL wr_prio_flags: got %02h want 00", rdata);
        end
        strobe();
        rd(0);
        n_checks++;
        if (rdata !== 8'h41) begin
            n_errors++;
            $display("FAIL wr_prio_next: got %02h want 41", rdata);
        end
    endtask

    task automatic test_reset_midcount();
        tick(1'b1, 1'b0, 1'b0, 0, 0);
        wr(1, 8);
        wr(4, 8'h02);
        wr(3, 8'h40);
        wr(0, 7);
        tick(1'b1, 1'b1, 1'b0, 0, 0);
        rd(0);
        n_checks++;
        if (rdata !== 8'h00 || TMO !== 1'b0 || CMIA !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid: got tcnt=%02h tmo=%b cmia=%b want 00/0/0", rdata, TMO, CMIA);
        end
        rd(4);
        n_checks++;
        if (rdata !== 8'h00) begin
            n_errors++;
            $display("FAIL rst_mid_tcsr: got %02h want 00", rdata);
        end
        rd(1);
        n_checks++;
        if (rdata !== 8'hFF) begin
            n_errors++;
            $display("FAIL rst_mid_tcora: got %02h want ff", rdata);
        end
    endtask

    task automatic test_random();
        bit           r, s, w;
        int           a, d;
        logic [W-1:0] exp_rd;
        logic [3:0]   exp_out;
        tick(1'b1, 1'b0, 1'b0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 1) == 1);
            w = ($urandom_range(0, 3) == 0);
            a = $urandom_range(0, 7);
            d = (a == 1 || a == 2) ? $urandom_range(0, 15) : $urandom_range(0, 255);
            if (a == 0 && $urandom_range(0, 1) == 1) d = $urandom_range(240, 255);
            tick(r, s, w, a, d);
            exp_rd  = W'(model_read(a));
            exp_out = {m_tmo, m_cmfa && m_cmiea, m_cmfb && m_cmieb, m_ovf && m_ovie};
            n_checks++;
            if (rdata !== exp_rd) begin
                n_errors++;
                $display("FAIL rand_rdata cycle %0d addr %0d: got %02h want %02h", n, a, rdata, exp_rd);
            end
            n_checks++;
            if ({TMO, CMIA, CMIB, OVI} !== exp_out) begin
                n_errors++;
                $display("FAIL rand_outputs cycle %0d: got %04b want %04b (tmo,cmia,cmib,ovi)",
                         n, {TMO, CMIA, CMIB, OVI}, exp_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clear_match_a();
        test_overflow();
        test_tmo_priority();
        test_flag_race();
        test_write_priority();
        test_reset_midcount();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the counter, compare and data-bus width.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port CounterClock  input  1  count strobe from the clock-select stage, one clk cycle wide per count event.
REQ-005 SHALL have port wr_en  input  1  register write strobe.
REQ-006 SHALL have port addr  input  3  register select: 0 TCNT, 1 TCORA, 2 TCORB, 3 TCR, 4 TCSR.
REQ-007 SHALL have port wdata  input  WIDTH  register write data.
REQ-008 SHALL have port rdata  output  WIDTH  combinational read of the register selected by addr; unmapped addresses read 0.
REQ-009 SHALL have port TMO  output  1  timer output pin.
REQ-010 SHALL have ports CMIA, CMIB, OVI  output  1 each  interrupt requests, level: flag AND its enable.

Function
REQ-011 TCR fields SHALL be: [1:0] CCLR (00 no clear, 01 clear on match A, 10 clear on match B, 11 no clear), [5] OVIE, [6] CMIEA, [7] CMIEB; other bits read 0.
REQ-012 TCSR fields SHALL be: [1:0] OSA, [3:2] OSB (00 none, 01 drive 0, 10 drive 1, 11 toggle), [5] OVF, [6] CMFA, [7] CMFB; bit 4 reads 0.
REQ-013 On a cycle with CounterClock=1, TCNT SHALL load 0 if the selected clear match holds (TCNT==TCORA for CCLR=01, TCNT==TCORB for CCLR=10); otherwise TCNT SHALL load TCNT+1 modulo 2^WIDTH.
REQ-014 Without CounterClock, TCNT SHALL hold.
REQ-015 A write to TCNT SHALL take priority over counting in the same cycle; no flag is set by that cycle's count.
REQ-016 CMFA SHALL set at the edge where CounterClock=1 and the new TCNT value equals TCORA; CMFB likewise for TCORB.
REQ-017 OVF SHALL set at the edge where CounterClock=1, TCNT=all-ones and no clear applies (wrap to 0).
REQ-018 A write to TCSR SHALL clear a flag where the written bit is 0 and leave it unchanged where it is 1; software cannot set a flag.
REQ-019 A hardware set SHALL win over a software clear in the same cycle.
REQ-020 On a match A (B) event per REQ-016, TMO SHALL update per OSA (OSB) at the same edge.
REQ-021 If matches A and B occur in the same cycle, the TMO priority SHALL be toggle > drive 1 > drive 0.
REQ-022 Writes to TCORA, TCORB, TCR and OS bits SHALL take effect on the following edge; a match condition created by the write alone SHALL NOT set a flag.

Reset
REQ-023 When rst=1 at an edge, the block SHALL set TCNT=0, TCORA=all-ones, TCORB=all-ones, TCR=0, TCSR=0 and TMO=0; rst SHALL override writes and counting in that cycle.
REQ-024 As a consequence of REQ-023, CMIA, CMIB and OVI SHALL be 0 in the cycle after reset.
REQ-025 Reset mid-count SHALL discard any pending match or overflow with no flag set.

Structure
REQ-026 Register addresses, CCLR encodings and OS encodings SHALL live in the shared package timer_pkg.
REQ-027 One sub-module, timer_compare, SHALL be instantiated twice (A, B) to produce the match event and the TMO action request; all remaining logic SHALL be flat.

Verification
REQ-028 Scenario: TCORA=5, CCLR=01, CMIEA=1, 12 strobes -> TCNT sequence 1..5,0,1..5,0; CMFA set after strobes 5 and 11; CMIA high from strobe 5.
REQ-029 Scenario: TCNT written to FE, CCLR=00, OVIE=1, 2 strobes -> TCNT FF then 00; OVF and OVI rise at the second strobe; CMFA/CMFB stay 0 with TCORA=TCORB=80.
REQ-030 Scenario: TCORA=TCORB=3, OSA=01, OSB=11, TMO=0, 3 strobes -> TMO=1 (toggle wins).
REQ-031 Scenario: CMFA=1, TCSR written with bit6=0 in the same cycle as a new match A -> CMFA remains 1.
REQ-032 Scenario: TCNT write of 0x40 coincident with a strobe -> TCNT=0x40, no flag change.
REQ-033 Scenario: rst asserted while TCNT=7 and a strobe is present -> TCNT=0, TMO=0, all flags 0 next cycle.
